// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue: circular buffer of {instruction, pc} pairs with push, pop and flush.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flush_i               - drop all entries (takes priority over push/pop)
//   push_i, push_data_i, push_pc_i - enqueue one instruction and its address
//   pop_i                 - dequeue the head
//   count_o               - current occupancy (0..QDEPTH)
//   head_data_o, head_pc_o - head entry, zero when empty
module inst_queue
    import cpu_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [INST_W-1:0]            push_data_i,
    input  logic [XLEN-1:0]              push_pc_i,
    input  logic                         pop_i,
    output logic [$clog2(QDEPTH+1)-1:0]  count_o,
    output logic [INST_W-1:0]            head_data_o,
    output logic [XLEN-1:0]              head_pc_o
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned PTR_W = $clog2(QDEPTH);

    logic [INST_W-1:0] data_q [QDEPTH];
    logic [XLEN-1:0]   pc_q   [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, do_push, do_pop;

    assign full    = (count_q == CNT_W'(QDEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i && !empty && !flush_i;
    // A full queue may accept a push only when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full || do_pop);

    // Pointer and occupancy next-state; QDEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr_q] <= push_data_i;
            pc_q[wr_ptr_q]   <= push_pc_i;
        end
    end

    // Fetch credit must make an overflowing push impossible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push_i && !flush_i && full && !do_pop))
                else $error("inst_queue: push into full queue");
        end
    end

    assign count_o     = count_q;
    assign head_data_o = empty ? '0 : data_q[rd_ptr_q];
    assign head_pc_o   = empty ? '0 : pc_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches under queue credit, tags in-order
// responses with their address, buffers them in inst_queue and hands them to decode.
// Redirect flushes the queue and discards in-flight responses; halt stops new fetches.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   imem_req_valid, imem_req_addr   - fetch request (always accepted by memory)
//   imem_resp_valid, imem_resp_data - in-order fetch response
//   redirect_valid, redirect_pc     - taken branch/jump target
//   halt                            - stop fetching (sticky until reset)
//   inst_valid, inst_ready          - decode handshake
//   inst_data, inst_pc              - head instruction and its address
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc
);

    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;
    // Discard count is bounded by memory round-trip latency, not by QDEPTH.
    localparam int unsigned DROP_W = 8;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  occ;
    logic [DROP_W-1:0] drop_q, drop_d, drop_fold;
    logic              credit_ok, resp_any, resp_live, push, pop;
    logic [XLEN-1:0]   resp_pc;
    logic [INST_W-1:0] head_data;
    logic [XLEN-1:0]   head_pc;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign credit_ok = (SUM_W'(occ) + SUM_W'(outst_q)) < SUM_W'(QDEPTH);
    assign resp_any  = imem_resp_valid && ((drop_q != '0) || (outst_q != '0));
    assign resp_live = imem_resp_valid && (drop_q == '0) && (outst_q != '0);
    // Every in-flight request becomes a discard; a response arriving now retires one of them.
    assign drop_fold = drop_q + DROP_W'(outst_q) - DROP_W'(resp_any);
    // Live requests are the last outst_q fetches, so the oldest sits outst_q words behind fetch_pc.
    assign resp_pc   = fetch_pc_q - XLEN'({outst_q, 2'b00});
    assign push      = resp_live && !redirect_valid && !reset;
    assign pop       = inst_valid && inst_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // FSM next state: halt is sticky until reset.
    always_comb begin
        state_d = state_q;
        if ((state_q == FETCH) && halt) state_d = HALTED;
    end

    // FSM outputs: fetch request.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = fetch_pc_q;
        if ((state_q == FETCH) && !reset && !redirect_valid && !halt && credit_ok) begin
            imem_req_valid = 1'b1;
        end
    end

    // Fetch pointer, live-request and discard counters.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            outst_d    = '0;
            drop_d     = drop_fold;
        end else begin
            if (imem_req_valid) fetch_pc_d = fetch_pc_q + XLEN'(4);
            outst_d = outst_q + CNT_W'(imem_req_valid) - CNT_W'(resp_live);
            if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
        end
    end

    // Reset keeps counting pre-reset requests as discards so their late responses are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= drop_fold;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    inst_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (imem_resp_data),
        .push_pc_i   (resp_pc),
        .pop_i       (pop),
        .count_o     (occ),
        .head_data_o (head_data),
        .head_pc_o   (head_pc)
    );

    assign inst_valid = (occ != '0) && !reset;
    assign inst_data  = reset ? '0 : head_data;
    assign inst_pc    = reset ? '0 : head_pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    inst_fetch_unit #(
        .QDEPTH   (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    typedef struct {
        logic [31:0] addr;
        int          remain;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] req_log[$];
    logic [31:0] del_log[$];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_rv;
        logic [31:0] exp_ra;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Fixed-latency in-order memory plus request/delivery logging.
    always @(negedge clk) begin
        pend_t p;
        foreach (pend[i]) pend[i].remain = pend[i].remain - 1;
        if (pend.size() > 0 && pend[0].remain <= 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        if (imem_req_valid && !reset) begin
            p.addr   = imem_req_addr;
            p.remain = lat;
            pend.push_back(p);
            req_log.push_back(imem_req_addr);
        end
        if (inst_valid && inst_ready) begin
            del_log.push_back(inst_pc);
            check("deliver_data", inst_data, mem_word(inst_pc));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        repeat (n) cycle();
        reset = 1'b0;
        req_log.delete();
        del_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, mem_word(32'h0)};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, mem_word(32'h4)};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, mem_word(32'h8)};

        // Reset state and startup pipeline, latency 1.
        lat = 1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            reset      = vecs[i].rst;
            inst_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_ra);
            check($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].exp_iv));
            check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst_data", i), inst_data, vecs[i].exp_data);
            cycle();
        end

        // Backpressure: queue fills with exactly 4 fetches, then resumes at 16.
        lat = 1;
        inst_ready = 1'b0;
        do_reset(4);
        repeat (10) cycle();
        @(negedge clk);
        check("bp_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check($sformatf("bp_req%0d", i), req_log[i], 32'(4 * i));
        check("bp_req_valid_stalled", 32'(imem_req_valid), 32'd0);
        check("bp_head_valid", 32'(inst_valid), 32'd1);
        check("bp_head_pc", inst_pc, 32'h0);
        cycle();
        inst_ready = 1'b1;
        repeat (20) cycle();
        @(negedge clk);
        check("bp_enough_delivered", 32'(del_log.size() >= 12), 32'd1);
        for (int i = 0; i < del_log.size(); i++)
            check($sformatf("bp_del%0d", i), del_log[i], 32'(4 * i));
        for (int i = 0; i < req_log.size(); i++)
            check($sformatf("bp_seq_req%0d", i), req_log[i], 32'(4 * i));

        // Redirect with three in flight, latency 3.
        lat = 3;
        inst_ready = 1'b1;
        do_reset(4);
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        check("rd_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_flushed_valid", 32'(inst_valid), 32'd0);
        repeat (15) cycle();
        @(negedge clk);
        check("rd_req_count_pre", 32'(req_log.size() >= 4), 32'd1);
        if (req_log.size() >= 4) check("rd_first_new_req", req_log[3], 32'h100);
        check("rd_del_count", 32'(del_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < del_log.size(); i++)
            check($sformatf("rd_del%0d", i), del_log[i], 32'h100 + 32'(4 * i));

        // Halt with two queued and one in flight.
        lat = 1;
        inst_ready = 1'b0;
        do_reset(4);
        repeat (3) cycle();
        halt = 1'b1;
        @(negedge clk);
        check("halt_no_req", 32'(imem_req_valid), 32'd0);
        cycle();
        halt       = 1'b0;
        inst_ready = 1'b1;
        repeat (55) cycle();
        @(negedge clk);
        check("halt_del_count", 32'(del_log.size()), 32'd3);
        for (int i = 0; i < del_log.size(); i++)
            check($sformatf("halt_del%0d", i), del_log[i], 32'(4 * i));
        check("halt_req_count", 32'(req_log.size()), 32'd3);
        check("halt_req_valid", 32'(imem_req_valid), 32'd0);
        check("halt_inst_valid", 32'(inst_valid), 32'd0);

        // Address wrap after redirect to a misaligned near-top address.
        lat = 1;
        inst_ready = 1'b1;
        do_reset(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();
        @(negedge clk);
        check("wrap_req_count", 32'(req_log.size() >= 3), 32'd1);
        check("wrap_del_count", 32'(del_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3) begin
            check("wrap_req0", req_log[0], 32'hFFFF_FFF8);
            check("wrap_req1", req_log[1], 32'hFFFF_FFFC);
            check("wrap_req2", req_log[2], 32'h0000_0000);
        end
        if (del_log.size() >= 3) begin
            check("wrap_del0", del_log[0], 32'hFFFF_FFF8);
            check("wrap_del1", del_log[1], 32'hFFFF_FFFC);
            check("wrap_del2", del_log[2], 32'h0000_0000);
        end

        // Mid-operation reset with two requests outstanding; late responses must be ignored.
        lat = 3;
        inst_ready = 1'b1;
        do_reset(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rst_outstanding", 32'(req_log.size()), 32'd2);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        cycle();
        reset = 1'b0;
        req_log.delete();
        del_log.delete();
        @(negedge clk);
        check("rst_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_first_req_addr", imem_req_addr, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("rst_iv_c%0d", k), 32'(inst_valid), 32'(k == 4));
            if (k == 4) begin
                check("rst_first_pc", inst_pc, 32'h0);
                check("rst_first_data", inst_data, mem_word(32'h0));
            end
            cycle();
        end
        repeat (4) cycle();
        @(negedge clk);
        check("rst_del_count", 32'(del_log.size() >= 2), 32'd1);
        for (int i = 0; i < 2 && i < del_log.size(); i++)
            check($sformatf("rst_del%0d", i), del_log[i], 32'(4 * i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
